// File: rtl/motor_agitation_scheduler_if.sv
// Bus between the cycle FSM and the drum motor scheduler.
// Signal suffixes are from the scheduler's point of view.
interface motor_agitation_scheduler_if;
    logic       enable_i;
    logic [1:0] phase_i;
    logic       pause_i;
    logic       door_closed_i;
    logic       motor_o;
    logic [1:0] motor_dir_o;
    logic       spin_full_o;
    logic [7:0] reversals_o;
    logic       fault_o;

    // Cycle FSM side: issues requests, watches motor status.
    modport master (
        output enable_i, phase_i, pause_i, door_closed_i,
        input  motor_o, motor_dir_o, spin_full_o, reversals_o, fault_o
    );

    // Scheduler side.
    modport slave (
        input  enable_i, phase_i, pause_i, door_closed_i,
        output motor_o, motor_dir_o, spin_full_o, reversals_o, fault_o
    );
endinterface

// File: rtl/motor_agitation_scheduler.sv
// Drum motor scheduler: alternating CW/CCW agitation with dead time,
// ramped spin, braking, pause freeze and door-open abort.
module motor_agitation_scheduler #(
    parameter int TICK_DIV        = 100,
    parameter int RUN_TICKS_WASH  = 8,
    parameter int RUN_TICKS_RINSE = 4,
    parameter int DEAD_TICKS      = 2,
    parameter int SPIN_RAMP_TICKS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    motor_agitation_scheduler_if.slave    ctl
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = 16;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] DEAD_LAST  = TW'(DEAD_TICKS - 1);
    localparam logic [TW-1:0] RAMP_LAST  = TW'(SPIN_RAMP_TICKS - 1);
    localparam logic [TW-1:0] WASH_LAST  = TW'(RUN_TICKS_WASH - 1);
    localparam logic [TW-1:0] RINSE_LAST = TW'(RUN_TICKS_RINSE - 1);

    typedef enum logic [2:0] {
        STOP, RUN_CW, DEAD_CW, RUN_CCW, DEAD_CCW, SPIN_RAMP, SPIN_FULL, BRAKE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    cur_phase_q, cur_phase_d;
    logic [7:0]    rev_q, rev_d;
    logic          fault_q, fault_d;
    logic          motor_q, motor_d;
    logic [1:0]    dir_q, dir_d;
    logic          spin_full_q, spin_full_d;

    logic          tick_pulse;
    logic          stop_req;
    logic [TW-1:0] run_last;
    logic [7:0]    rev_inc;

    assign tick_pulse = (presc_q == PRESC_LAST);
    // Phase 11 never equals a latched phase, so it also forces a stop.
    assign stop_req   = !ctl.enable_i || (ctl.phase_i != cur_phase_q) || (ctl.phase_i == 2'b11);
    assign run_last   = (cur_phase_q == 2'b01) ? RINSE_LAST : WASH_LAST;
    assign rev_inc    = (rev_q == 8'hFF) ? 8'hFF : rev_q + 8'd1;

    // Next-state, counters, interlocks and registered output decode.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        tick_d      = tick_q;
        cur_phase_d = cur_phase_q;
        rev_d       = rev_q;
        fault_d     = fault_q;

        if (state_q == STOP) begin
            if (fault_q && !ctl.enable_i && ctl.door_closed_i)
                fault_d = 1'b0;
            if (!fault_q && ctl.enable_i && ctl.door_closed_i && !ctl.pause_i) begin
                if (ctl.phase_i == 2'b00 || ctl.phase_i == 2'b01) begin
                    state_d     = RUN_CW;
                    cur_phase_d = ctl.phase_i;
                    rev_d       = 8'd0;
                end else if (ctl.phase_i == 2'b10) begin
                    state_d     = SPIN_RAMP;
                    cur_phase_d = ctl.phase_i;
                end
            end
        end else if (!ctl.door_closed_i) begin
            // Door opened under load: cut power at once, no braking phase.
            state_d = STOP;
            fault_d = 1'b1;
        end else if (state_q != BRAKE && stop_req) begin
            state_d = BRAKE;
        end else if (!ctl.pause_i) begin
            presc_d = tick_pulse ? '0 : presc_q + PW'(1);
            // SPIN_FULL is held forever, so its tick count is frozen to avoid wrap.
            if (tick_pulse && state_q != SPIN_FULL)
                tick_d = tick_q + TW'(1);
            if (tick_pulse) begin
                case (state_q)
                    RUN_CW:    if (tick_q == run_last)  state_d = DEAD_CW;
                    DEAD_CW:   if (tick_q == DEAD_LAST) begin state_d = RUN_CCW; rev_d = rev_inc; end
                    RUN_CCW:   if (tick_q == run_last)  state_d = DEAD_CCW;
                    DEAD_CCW:  if (tick_q == DEAD_LAST) begin state_d = RUN_CW; rev_d = rev_inc; end
                    SPIN_RAMP: if (tick_q == RAMP_LAST) state_d = SPIN_FULL;
                    BRAKE:     if (tick_q == DEAD_LAST) state_d = STOP;
                    default:   ;
                endcase
            end
        end

        if (state_d != state_q) begin
            presc_d = '0;
            tick_d  = '0;
        end

        motor_d     = 1'b0;
        dir_d       = 2'b00;
        spin_full_d = (state_d == SPIN_FULL);
        case (state_d)
            RUN_CW, SPIN_RAMP, SPIN_FULL: begin motor_d = 1'b1; dir_d = 2'b01; end
            RUN_CCW:                      begin motor_d = 1'b1; dir_d = 2'b10; end
            default:                      ;
        endcase
        // A held pause keeps the motor de-energised without losing position.
        if (ctl.pause_i && state_q != STOP) begin
            motor_d = 1'b0;
            dir_d   = 2'b00;
        end
    end

    // State and output registers; reset parks the motor immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STOP;
            presc_q     <= '0;
            tick_q      <= '0;
            cur_phase_q <= 2'b00;
            rev_q       <= 8'd0;
            fault_q     <= 1'b0;
            motor_q     <= 1'b0;
            dir_q       <= 2'b00;
            spin_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            cur_phase_q <= cur_phase_d;
            rev_q       <= rev_d;
            fault_q     <= fault_d;
            motor_q     <= motor_d;
            dir_q       <= dir_d;
            spin_full_q <= spin_full_d;
        end
    end

    assign ctl.motor_o     = motor_q;
    assign ctl.motor_dir_o = dir_q;
    assign ctl.spin_full_o = spin_full_q;
    assign ctl.reversals_o = rev_q;
    assign ctl.fault_o     = fault_q;
endmodule

// File: tb/tb_motor_agitation_scheduler.sv
// Directed bench for motor_agitation_scheduler with TICK_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_motor_agitation_scheduler;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    motor_agitation_scheduler_if bus();

    motor_agitation_scheduler #(
        .TICK_DIV(TD), .RUN_TICKS_WASH(8), .RUN_TICKS_RINSE(4),
        .DEAD_TICKS(2), .SPIN_RAMP_TICKS(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Counts consecutive sampled cycles with motor_dir == d, starting now.
    task automatic run_len(input logic [1:0] d, output int len);
        len = 0;
        while (bus.motor_dir_o == d && len < 400) begin
            len++;
            step(1);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.enable_i      = 1'b0;
        bus.phase_i       = 2'b00;
        bus.pause_i       = 1'b0;
        bus.door_closed_i = 1'b1;
        step(3);
        chk("rst_motor", bus.motor_o, 0);
        chk("rst_dir", bus.motor_dir_o, 0);
        chk("rst_spin_full", bus.spin_full_o, 0);
        chk("rst_reversals", bus.reversals_o, 0);
        chk("rst_fault", bus.fault_o, 0);
        rst_n = 1'b1;
        step(2);

        // Wash: 32 CW, 8 off, 32 CCW, 8 off, CW again.
        bus.enable_i = 1'b1;
        bus.phase_i  = 2'b00;
        step(1);
        chk("start_latency_motor", bus.motor_o, 1);
        run_len(2'b01, n); chk("wash_cw_len", n, 32);
        run_len(2'b00, n); chk("wash_dead1_len", n, 8);
        chk("wash_rev1", bus.reversals_o, 1);
        run_len(2'b10, n); chk("wash_ccw_len", n, 32);
        run_len(2'b00, n); chk("wash_dead2_len", n, 8);
        chk("wash_rev2", bus.reversals_o, 2);
        chk("wash_cw_again", bus.motor_dir_o, 2'b01);

        // Phase change mid-run: 8 brake + 1 stop cycle, then rinse restart.
        step(5);
        bus.phase_i = 2'b01;
        step(1);
        chk("phase_chg_motor", bus.motor_o, 0);
        run_len(2'b00, n); chk("brake_plus_stop_len", n, 9);
        chk("rinse_rev_cleared", bus.reversals_o, 0);
        run_len(2'b01, n); chk("rinse_cw_len", n, 16);
        run_len(2'b00, n); chk("rinse_dead_len", n, 8);
        chk("rinse_rev1", bus.reversals_o, 1);
        run_len(2'b10, n); chk("rinse_ccw_len", n, 16);
        bus.enable_i = 1'b0;
        step(12);
        chk("idle_motor", bus.motor_o, 0);

        // Pause at cycle 10 of RUN_CW for 50 cycles; 22 CW cycles remain.
        bus.phase_i  = 2'b00;
        bus.enable_i = 1'b1;
        step(1);
        chk("pause_run_start", bus.motor_dir_o, 2'b01);
        step(9);
        bus.pause_i = 1'b1;
        step(1);
        chk("pause_motor", bus.motor_o, 0);
        chk("pause_dir", bus.motor_dir_o, 0);
        step(49);
        chk("pause_hold_dir", bus.motor_dir_o, 0);
        bus.pause_i = 1'b0;
        step(1);
        run_len(2'b01, n); chk("pause_remaining_cw", n, 22);
        run_len(2'b00, n); chk("pause_dead_len", n, 8);
        chk("pause_ccw", bus.motor_dir_o, 2'b10);

        // Door abort mid RUN_CCW.
        step(5);
        bus.door_closed_i = 1'b0;
        step(1);
        chk("door_motor", bus.motor_o, 0);
        chk("door_dir", bus.motor_dir_o, 0);
        chk("door_fault", bus.fault_o, 1);
        bus.door_closed_i = 1'b1;
        step(5);
        chk("fault_blocks_start", bus.motor_o, 0);
        chk("fault_sticky", bus.fault_o, 1);
        bus.enable_i = 1'b0;
        step(1);
        chk("fault_cleared", bus.fault_o, 0);

        // Spin: 16 ramp cycles, then full speed; brake lasts 8 cycles.
        bus.phase_i  = 2'b10;
        bus.enable_i = 1'b1;
        step(1);
        chk("spin_dir", bus.motor_dir_o, 2'b01);
        n = 0;
        while (bus.spin_full_o == 1'b0 && n < 400) begin
            n++;
            step(1);
        end
        chk("spin_ramp_len", n, 16);
        chk("spin_full_dir", bus.motor_dir_o, 2'b01);
        step(20);
        chk("spin_full_held", bus.spin_full_o, 1);
        bus.enable_i = 1'b0;
        step(1);
        chk("spin_drop_motor", bus.motor_o, 0);
        chk("spin_drop_full", bus.spin_full_o, 0);
        step(7);
        bus.enable_i = 1'b1;
        step(1);
        chk("brake_no_restart", bus.motor_o, 0);
        step(1);
        chk("restart_after_brake", bus.motor_o, 1);
        bus.enable_i = 1'b0;
        step(12);

        // Asynchronous reset during RUN_CCW.
        bus.phase_i  = 2'b00;
        bus.enable_i = 1'b1;
        step(1);
        step(43);
        chk("pre_reset_ccw", bus.motor_dir_o, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_motor", bus.motor_o, 0);
        chk("async_rst_dir", bus.motor_dir_o, 0);
        chk("async_rst_reversals", bus.reversals_o, 0);
        chk("async_rst_spin_full", bus.spin_full_o, 0);
        bus.enable_i = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);

        // Saturation: ~300 rinse reversals at 24 cycles each.
        bus.phase_i  = 2'b01;
        bus.enable_i = 1'b1;
        step(7400);
        chk("reversals_saturate", bus.reversals_o, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/motor_agitation_scheduler.md
# motor_agitation_scheduler

- Sequences the drum motor for the washing machine.
- Turns the controller's "agitate in phase X" request into a safe motor enable and direction pattern:
  - alternating CW/CCW runs with dead time between reversals for wash and rinse;
  - a ramped one-direction spin for the spin phase.
- Owns every motor interlock: pause freeze, door-open abort, braking before stop.
- Sits between the cycle FSM and the motor/motor_dir pins of the top level.

## Interface

Parameters:
- TICK_DIV, 100: clk cycles per scheduler tick (≥2).
- RUN_TICKS_WASH, 8: ticks per directional run in wash.
- RUN_TICKS_RINSE, 4: ticks per directional run in rinse.
- DEAD_TICKS, 2: motor-off ticks between reversals and for braking.
- SPIN_RAMP_TICKS, 4: ticks of ramp before full spin.

Ports:
- clk  in  1  system clock, all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; one clock domain only.
- enable  in  1  FSM requests motor activity.
- phase  in  2  00 wash, 01 rinse, 10 spin, 11 reserved (treated as enable=0).
- pause  in  1  level; freezes scheduling.
- door_closed  in  1  1 = door latched.
- motor  out  1  motor power.
- motor_dir  out  2  00 stop, 01 CW, 10 CCW; 11 never driven.
- spin_full  out  1  spin at full speed.
- reversals  out  8  direction changes since leaving STOP; saturates at 255.
- fault  out  1  sticky door-open-while-active flag.

## Operation

- States: STOP, RUN_CW, DEAD_CW, RUN_CCW, DEAD_CCW, SPIN_RAMP, SPIN_FULL, BRAKE.
- Outputs are decoded from the registered state:
  - motor=1 only in RUN_CW, RUN_CCW, SPIN_RAMP, SPIN_FULL.
  - motor_dir=01 in RUN_CW, SPIN_RAMP, SPIN_FULL; 10 in RUN_CCW; 00 elsewhere.
  - spin_full=1 only in SPIN_FULL.
- Timing base:
  - A prescaler counts 0..TICK_DIV-1 and pulses a tick on TICK_DIV-1.
  - A tick counter counts ticks within the current state.
  - Both counters clear on every state transition.
- Transitions from STOP:
  - STOP, enable=1, door_closed=1, pause=0, phase 00/01 → RUN_CW; latch phase into cur_phase; clear reversals.
  - STOP, same conditions, phase 10 → SPIN_RAMP; latch phase into cur_phase.
- Agitation cycle:
  - RUN_CW → DEAD_CW after RUN_TICKS (per cur_phase).
  - DEAD_CW → RUN_CCW after DEAD_TICKS.
  - RUN_CCW → DEAD_CCW after RUN_TICKS.
  - DEAD_CCW → RUN_CW after DEAD_TICKS.
  - reversals increments on each entry into RUN_CCW and each entry into RUN_CW from DEAD_CCW.
- Spin:
  - SPIN_RAMP → SPIN_FULL after SPIN_RAMP_TICKS.
  - SPIN_FULL is held indefinitely.
- Stopping:
  - Any motor-active or dead state goes to BRAKE when enable=0, or phase≠cur_phase, or phase=11.
  - BRAKE → STOP after DEAD_TICKS.
  - A new request is honoured only from STOP.
- Pause:
  - pause=1 in any non-STOP state freezes the prescaler, tick counter and state, and forces motor=0 and motor_dir=00.
  - On release, the same state resumes with its remaining count.
  - pause in STOP blocks the start.
- Door:
  - door_closed=0 in any non-STOP state → STOP immediately, skipping BRAKE; fault←1.
  - fault clears only when in STOP with enable=0 and door_closed=1.
  - While fault=1, STOP does not restart.
- Priority: reset > door open > enable drop / phase change > pause > tick expiry.
- Safety invariant: motor_dir never changes directly between 01 and 10; at least DEAD_TICKS*TICK_DIV cycles of 00 lie between them.

## Timing

- Reset (reset=0, asynchronous):
  - state=STOP, counters=0, cur_phase=00, reversals=0, fault=0.
  - motor=0, motor_dir=00, spin_full=0.
- Start latency: 1 cycle. A request sampled at edge N shows motor=1 after edge N.
- Run duration: exactly RUN_TICKS*TICK_DIV cycles.
- Dead and brake duration: exactly DEAD_TICKS*TICK_DIV cycles.
- Spin ramp duration: exactly SPIN_RAMP_TICKS*TICK_DIV cycles.
- Pause effect: takes effect on the next edge; paused cycles are not counted.
- Door abort: motor=0 one edge after door_closed falls.
- Simultaneous events at one edge: door open beats enable drop and tick expiry. enable drop beats an expiring tick, so the state goes to BRAKE, not the next run.
- reversals at 255 stays 255.

## Test plan

- Wash cycle (TICK_DIV=4, RUN_TICKS_WASH=8, DEAD_TICKS=2):
  - Stimulus: enable=1, phase=00.
  - Required: 32 cycles dir=01, then 8 cycles 00, then 32 cycles 10 (reversals=1), then 8 cycles 00, then 01 again (reversals=2).
- Spin cycle:
  - Stimulus: phase=10, enable=1.
  - Required: 16 cycles dir=01 with spin_full=0, then spin_full=1.
  - Then drop enable: motor=0 next edge; STOP after 8 cycles.
- Pause:
  - Stimulus: pause 50 cycles at cycle 10 of RUN_CW.
  - Required: motor=0 and dir=00 during pause; after release, 22 cycles of dir=01 remain, then DEAD_CW.
- Door abort:
  - Stimulus: door_closed=0 mid RUN_CCW.
  - Required: next edge motor=0, dir=00, fault=1.
  - Reassert enable with door closed: motor stays off until enable=0 with door closed, then fault=0.
- Phase change:
  - Stimulus: phase 00→01 mid-run.
  - Required: BRAKE for 8 cycles, then STOP; restart in rinse with 16-cycle runs.
- Reset mid-run:
  - Stimulus: reset=0 asynchronously during RUN_CCW.
  - Required: all outputs 0 without waiting for a clock edge.
- Saturation: force 300 reversals → reversals=255.
